// File: rtl/zx_mem_pkg.sv
// zx_mem_pkg: shared types and constants for the ZX memory arbiter
package zx_mem_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_LDR} owner_t;
endpackage

// File: rtl/zx_prio_pick.sv
// zx_prio_pick: one-hot winner select, video > cpu > loader, with cpu starvation override
module zx_prio_pick
    import zx_mem_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 6
) (
    input  logic [2:0] req,
    input  logic [2:0] mask,
    input  logic [3:0] wait_cnt,
    output logic [2:0] grant
);
    localparam logic [3:0] MAX_W = 4'(CPU_MAX_WAIT);
    logic [2:0] live;
    // stale requests (ack high this cycle) are masked before picking
    always_comb begin
        live  = req & ~mask;
        grant = (live[1] && wait_cnt >= MAX_W) ? 3'b010 :
                live[0] ? 3'b001 :
                live[1] ? 3'b010 :
                live[2] ? 3'b100 : 3'b000;
    end
endmodule

// File: rtl/zx_mem_arbiter.sv
// zx_mem_arbiter: shares one synchronous RAM between video, Z80 and tape loader
module zx_mem_arbiter
    import zx_mem_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int RAM_LAT      = 1,
    parameter int CPU_MAX_WAIT = 6
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_nwait,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);
    state_t            state, state_n;
    owner_t            owner;
    logic [1:0]        lat_cnt;
    logic [3:0]        wait_cnt;
    logic [2:0]        grant;
    logic              granted;
    logic              cpu_owns;
    logic [DATA_W-1:0] cpu_hold, vid_hold, ldr_hold;

    assign granted   = state == IDLE && |grant;
    assign cpu_owns  = state != IDLE && owner == OWN_CPU;
    assign vid_ack   = state == DONE && owner == OWN_VID;
    assign cpu_ack   = state == DONE && owner == OWN_CPU;
    assign ldr_ack   = state == DONE && owner == OWN_LDR;
    assign vid_rdata = vid_ack ? ram_rdata : vid_hold;
    assign cpu_rdata = cpu_ack ? ram_rdata : cpu_hold;
    assign ldr_rdata = ldr_ack ? ram_rdata : ldr_hold;
    assign cpu_nwait = ~(cpu_req & ~cpu_ack);

    zx_prio_pick #(.CPU_MAX_WAIT(CPU_MAX_WAIT)) u_pick (
        .req      ({ldr_req, cpu_req, vid_req}),
        .mask     ({ldr_ack, cpu_ack, vid_ack}),
        .wait_cnt (wait_cnt),
        .grant    (grant)
    );

    // state register
    always_ff @(posedge CLOCK) state <= RESET_N ? state_n : IDLE;

    // grant -> ACCESS for RAM_LAT cycles -> one DONE cycle -> IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |grant ? ACCESS : IDLE;
            ACCESS:  state_n = lat_cnt == 2'd1 ? DONE : ACCESS;
            default: state_n = IDLE;
        endcase
    end

    // drive the winner onto the RAM port and keep each requester's last read data
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            owner     <= OWN_VID;
            lat_cnt   <= '0;
            cpu_hold  <= '0;
            vid_hold  <= '0;
            ldr_hold  <= '0;
        end else begin
            ram_we <= 1'b0;
            if (granted) begin
                ram_addr  <= grant[0] ? vid_addr : grant[1] ? cpu_addr : ldr_addr;
                ram_wdata <= grant[0] ? {DATA_W{1'b0}} : grant[1] ? cpu_wdata : ldr_wdata;
                ram_we    <= grant[1] ? cpu_we : grant[2] & ldr_we;
                owner     <= grant[0] ? OWN_VID : grant[1] ? OWN_CPU : OWN_LDR;
                lat_cnt   <= 2'(RAM_LAT);
            end else if (state == ACCESS)
                lat_cnt <= lat_cnt - 2'd1;
            if (vid_ack) vid_hold <= ram_rdata;
            if (cpu_ack) cpu_hold <= ram_rdata;
            if (ldr_ack) ldr_hold <= ram_rdata;
        end
    end

    // cpu starvation counter: runs while the cpu waits behind another owner, saturates at 15
    always_ff @(posedge CLOCK) begin
        if (!RESET_N || !cpu_req || (granted && grant[1]))
            wait_cnt <= '0;
        else if (!cpu_owns && wait_cnt != 4'hF)
            wait_cnt <= wait_cnt + 4'd1;
    end
endmodule

// File: tb/tb_zx_mem_arbiter.sv
// tb_zx_mem_arbiter: scoreboard bench for the RAM arbiter (RAM_LAT 1 and 3 instances)
module tb_zx_mem_arbiter;
    localparam int P_ADDR = 0, P_WE = 1, P_WDATA = 2, P_NWAIT = 3, P_CRD = 4, P_VRD = 5,
                   P_LRD = 6, P_ACKS = 7, P_WAIT = 8, P_STATE = 9, P_NWAIT3 = 10;

    typedef struct { int cyc; int who; logic [7:0] data; bit chk; } exp_t;
    typedef struct { int cyc; int id; int unsigned val; string name; } probe_t;

    logic        CLOCK = 1'b0, RESET_N = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, vid_req = 0, ldr_req = 0, ldr_we = 0;
    logic [16:0] cpu_addr = 0, vid_addr = 0, ldr_addr = 0;
    logic [7:0]  cpu_wdata = 0, ldr_wdata = 0;
    logic        cpu_ack, cpu_nwait, vid_ack, ldr_ack, ram_we;
    logic [7:0]  cpu_rdata, vid_rdata, ldr_rdata, ram_wdata, ram_rdata;
    logic [16:0] ram_addr;

    logic        cpu3_req = 0;
    logic [16:0] cpu3_addr = 0;
    logic        cpu3_ack, cpu3_nwait, v3_ack, l3_ack, ram3_we;
    logic [7:0]  cpu3_rdata, v3_rdata, l3_rdata, ram3_wdata, ram3_rdata, r1, r2;
    logic [16:0] ram3_addr;

    logic        pre_we = 0;
    logic [16:0] pre_addr = 0;
    logic [7:0]  pre_data = 0;
    logic [7:0]  mem  [0:131071];
    logic [7:0]  mem3 [0:131071];

    int     cyc = 0, n_tests = 0, n_fail = 0;
    bit     hold_vid = 0, hold_cpu3 = 0, done = 0, fin = 0;
    exp_t   sb[$];
    probe_t pq[$];

    zx_mem_arbiter #(.ADDR_W(17), .RAM_LAT(1), .CPU_MAX_WAIT(6)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_nwait(cpu_nwait),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    zx_mem_arbiter #(.ADDR_W(17), .RAM_LAT(3), .CPU_MAX_WAIT(6)) dut3 (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .cpu_req(cpu3_req), .cpu_we(1'b0), .cpu_addr(cpu3_addr), .cpu_wdata(8'h00),
        .cpu_ack(cpu3_ack), .cpu_rdata(cpu3_rdata), .cpu_nwait(cpu3_nwait),
        .vid_req(1'b0), .vid_addr(17'h0), .vid_ack(v3_ack), .vid_rdata(v3_rdata),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(17'h0), .ldr_wdata(8'h00),
        .ldr_ack(l3_ack), .ldr_rdata(l3_rdata),
        .ram_addr(ram3_addr), .ram_wdata(ram3_wdata), .ram_we(ram3_we), .ram_rdata(ram3_rdata)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // RAM models: 1-cycle and 3-cycle read latency, with a bench preload port
    always @(posedge CLOCK) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (pre_we) mem[pre_addr] <= pre_data;
        ram_rdata <= mem[ram_addr];
    end
    always @(posedge CLOCK) begin
        if (ram3_we) mem3[ram3_addr] <= ram3_wdata;
        if (pre_we) mem3[pre_addr] <= pre_data;
        r1 <= mem3[ram3_addr];
        r2 <= r1;
        ram3_rdata <= r2;
    end

    function automatic logic [7:0] rd(input int w);
        return w == 0 ? vid_rdata : w == 1 ? cpu_rdata : w == 2 ? ldr_rdata : cpu3_rdata;
    endfunction

    function automatic int unsigned pval(input int id);
        case (id)
            P_ADDR:   return 32'(ram_addr);
            P_WE:     return 32'(ram_we);
            P_WDATA:  return 32'(ram_wdata);
            P_NWAIT:  return 32'(cpu_nwait);
            P_CRD:    return 32'(cpu_rdata);
            P_VRD:    return 32'(vid_rdata);
            P_LRD:    return 32'(ldr_rdata);
            P_ACKS:   return 32'({ldr_ack, cpu_ack, vid_ack});
            P_WAIT:   return 32'(dut.wait_cnt);
            P_STATE:  return 32'(dut.state);
            P_NWAIT3: return 32'(cpu3_nwait);
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    // monitor: pops expected acks as they appear and checks probes due this cycle
    always @(negedge CLOCK) begin
        logic [3:0] a;
        exp_t e;
        a = {cpu3_ack, ldr_ack, cpu_ack, vid_ack};
        for (int w = 0; w < 4; w++) begin
            if (a[w]) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: requester %0d acked at cycle %0d, none expected", w, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.who != w || e.cyc != cyc || (e.chk && rd(w) != e.data)) begin
                        n_fail++;
                        $display("FAIL ack: got who=%0d cyc=%0d data=%02h, want who=%0d cyc=%0d data=%02h",
                                 w, cyc, rd(w), e.who, e.cyc, e.data);
                    end
                end
            end
        end
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].cyc == cyc) begin
                n_tests++;
                if (pval(pq[i].id) != pq[i].val) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got %0h, want %0h", pq[i].name, cyc, pval(pq[i].id), pq[i].val);
                end
                pq.delete(i);
            end else if (pq[i].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: probe for cycle %0d not evaluated", pq[i].name, pq[i].cyc);
                pq.delete(i);
            end
        end
        if (done && !fin) begin
            n_tests++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL acks_pending: got %0d outstanding, want 0", sb.size());
            end
            fin = 1;
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // run n cycles; one-shot requesters drop req the cycle after their ack
    task automatic cycles(input int n);
        logic [3:0] a;
        repeat (n) begin
            @(negedge CLOCK);
            a = {cpu3_ack, ldr_ack, cpu_ack, vid_ack};
            step();
            if (a[0] && !hold_vid) vid_req = 0;
            if (a[1]) cpu_req = 0;
            if (a[2]) ldr_req = 0;
            if (a[3] && !hold_cpu3) cpu3_req = 0;
        end
    endtask

    task automatic exp_ack(input int c, input int w, input logic [7:0] d, input bit chk);
        sb.push_back('{c, w, d, chk});
    endtask

    task automatic probe(input int c, input int id, input int unsigned v, input string nm);
        pq.push_back('{c, id, v, nm});
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we = 1;
        step();
        pre_we = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1);
    end

    initial begin
        int t0;
        step();
        step();
        probe(cyc, P_ACKS, 0, "rst_acks");
        probe(cyc, P_WE, 0, "rst_ram_we");
        probe(cyc, P_ADDR, 0, "rst_ram_addr");
        probe(cyc, P_WDATA, 0, "rst_ram_wdata");
        probe(cyc, P_CRD, 0, "rst_cpu_rdata");
        probe(cyc, P_NWAIT, 1, "rst_nwait");
        probe(cyc, P_STATE, 0, "rst_state");
        probe(cyc, P_WAIT, 0, "rst_wait_cnt");
        RESET_N = 1;
        preload(17'h0A123, 8'h5C);
        preload(17'h00010, 8'h11);
        preload(17'h00020, 8'h22);
        preload(17'h00030, 8'h33);
        preload(17'h00100, 8'h3C);

        // cpu read
        cpu_req = 1; cpu_we = 0; cpu_addr = 17'h0A123; t0 = cyc;
        exp_ack(t0 + 2, 1, 8'h5C, 1);
        probe(t0, P_NWAIT, 0, "rd_nwait_c0");
        probe(t0 + 1, P_NWAIT, 0, "rd_nwait_c1");
        probe(t0 + 1, P_ADDR, 17'h0A123, "rd_ram_addr");
        probe(t0 + 1, P_WE, 0, "rd_ram_we");
        probe(t0 + 2, P_NWAIT, 1, "rd_nwait_ack");
        probe(t0 + 3, P_CRD, 8'h5C, "rd_rdata_held");
        cycles(4);

        // cpu write, then video reads it back
        cpu_req = 1; cpu_we = 1; cpu_addr = 17'h14000; cpu_wdata = 8'hA5; t0 = cyc;
        exp_ack(t0 + 2, 1, 8'h00, 0);
        probe(t0 + 1, P_WE, 1, "wr_ram_we");
        probe(t0 + 1, P_WDATA, 8'hA5, "wr_ram_wdata");
        probe(t0 + 1, P_ADDR, 17'h14000, "wr_ram_addr");
        probe(t0 + 2, P_WE, 0, "wr_ram_we_off");
        cycles(4);
        cpu_we = 0;
        vid_req = 1; vid_addr = 17'h14000; t0 = cyc;
        exp_ack(t0 + 2, 0, 8'hA5, 1);
        probe(t0 + 1, P_WE, 0, "vrd_ram_we");
        cycles(4);

        // three-way contention: vid read, cpu write, ldr write
        vid_req = 1; vid_addr = 17'h00010;
        cpu_req = 1; cpu_we = 1; cpu_addr = 17'h00020; cpu_wdata = 8'h77;
        ldr_req = 1; ldr_we = 1; ldr_addr = 17'h00030; ldr_wdata = 8'h88; t0 = cyc;
        exp_ack(t0 + 2, 0, 8'h11, 1);
        exp_ack(t0 + 5, 1, 8'h00, 0);
        exp_ack(t0 + 8, 2, 8'h00, 0);
        for (int k = 1; k <= 8; k++) probe(t0 + k, P_WE, (k == 4 || k == 7) ? 1 : 0, "cont_ram_we");
        probe(t0 + 4, P_ADDR, 17'h00020, "cont_cpu_addr");
        probe(t0 + 7, P_ADDR, 17'h00030, "cont_ldr_addr");
        probe(t0 + 7, P_WDATA, 8'h88, "cont_ldr_wdata");
        probe(t0 + 3, P_NWAIT, 0, "cont_nwait");
        cycles(10);
        cpu_we = 0; ldr_we = 0;

        // starvation guard: video held, cpu pre-empts once wait_cnt hits 6
        hold_vid = 1; vid_req = 1; vid_addr = 17'h00010;
        cpu_req = 1; cpu_addr = 17'h00020; t0 = cyc;
        exp_ack(t0 + 2, 0, 8'h11, 1);
        exp_ack(t0 + 5, 0, 8'h11, 1);
        exp_ack(t0 + 8, 1, 8'h77, 1);
        exp_ack(t0 + 11, 0, 8'h11, 1);
        probe(t0 + 3, P_WAIT, 3, "starve_wait3");
        probe(t0 + 6, P_WAIT, 6, "starve_wait6");
        probe(t0 + 7, P_WAIT, 0, "starve_wait_clr");
        probe(t0 + 7, P_ADDR, 17'h00020, "starve_cpu_addr");
        probe(t0 + 9, P_WAIT, 0, "starve_wait_after");
        cycles(9);
        hold_vid = 0;
        cycles(4);

        // reset during ACCESS of a cpu write
        cpu_req = 1; cpu_we = 1; cpu_addr = 17'h00040; cpu_wdata = 8'h99; t0 = cyc;
        probe(t0 + 1, P_WE, 1, "rstm_ram_we_pre");
        probe(t0 + 2, P_STATE, 0, "rstm_state");
        probe(t0 + 2, P_WE, 0, "rstm_ram_we");
        probe(t0 + 2, P_ADDR, 0, "rstm_ram_addr");
        probe(t0 + 2, P_WDATA, 0, "rstm_ram_wdata");
        probe(t0 + 2, P_CRD, 0, "rstm_cpu_rdata");
        probe(t0 + 2, P_VRD, 0, "rstm_vid_rdata");
        probe(t0 + 2, P_LRD, 0, "rstm_ldr_rdata");
        probe(t0 + 2, P_ACKS, 0, "rstm_acks");
        probe(t0 + 2, P_NWAIT, 1, "rstm_nwait");
        probe(t0 + 3, P_ACKS, 0, "rstm_acks_after");
        step();
        RESET_N = 0;
        step();
        RESET_N = 1; cpu_req = 0; cpu_we = 0;
        cycles(3);

        // RAM_LAT = 3: held cpu read acks at 4, then every 5 cycles
        hold_cpu3 = 1; cpu3_req = 1; cpu3_addr = 17'h00100; t0 = cyc;
        exp_ack(t0 + 4, 3, 8'h3C, 1);
        exp_ack(t0 + 9, 3, 8'h3C, 1);
        exp_ack(t0 + 14, 3, 8'h3C, 1);
        probe(t0 + 3, P_NWAIT3, 0, "lat3_nwait_wait");
        probe(t0 + 4, P_NWAIT3, 1, "lat3_nwait_ack");
        cycles(13);
        hold_cpu3 = 0;
        cycles(4);

        done = 1;
        wait (fin);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/zx_mem_arbiter.md
Name: zx_mem_arbiter

Overview:
- Shares one single-port synchronous 128k RAM between three requesters: Z80 bus, video fetch, TAP/DMA loader.
- Sits between the CPU memory-decode logic (already-banked 17-bit address), the video adapter and the tape loader, and the RAM macro.
- Drives the Z80 nWAIT line so the CPU stalls while its access is pending.
- Fixed priority video > cpu > loader, with a starvation guard that lets the CPU pre-empt video after a bounded wait.

Parameters:
- ADDR_W, 17, RAM address width (128k).
- RAM_LAT, 1, RAM read latency in cycles, from registered address to valid ram_rdata; legal range 1..3.
- CPU_MAX_WAIT, 6, pending-wait cycles after which the CPU outranks video for one grant.

Ports:
- CLOCK  in  1  arbiter clock.
- RESET_N  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  banked address.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data, valid while cpu_ack = 1, held afterwards.
- cpu_nwait  out  1  Z80 WAIT, active-low.
- vid_req  in  1  video fetch request (read only).
- vid_addr  in  ADDR_W  address.
- vid_ack  out  1  completion pulse.
- vid_rdata  out  8  read data.
- ldr_req  in  1  loader request.
- ldr_we  in  1  1 = write.
- ldr_addr  in  ADDR_W  address.
- ldr_wdata  in  8  write data.
- ldr_ack  out  1  completion pulse.
- ldr_rdata  out  8  read data.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  8  registered write data.
- ram_we  out  1  registered write strobe.
- ram_rdata  in  8  RAM output.

Behaviour:
- **Reset** (RESET_N = 0 at a CLOCK edge) clears state to IDLE; aborts any in-flight access without ack.
  - Reset values: all acks 0, ram_we 0, ram_addr 0, ram_wdata 0, all rdata 0, wait counter 0, latency counter 0.
- **IDLE:** sample requests and select a winner.
  - cpu wins if cpu_req and wait_cnt >= CPU_MAX_WAIT.
  - Otherwise the order is vid, then cpu, then ldr.
  - A requester whose ack is high this cycle is ignored (its req is stale).
  - On a grant, register the winner's addr, wdata and we into ram_*. ram_we = 1 for that one access cycle only (video forces 0). Record the owner. Go to ACCESS with lat_cnt = RAM_LAT.
- **ACCESS:** ram_we returns to 0 after the first cycle; lat_cnt decrements each cycle. At lat_cnt = 1, go to DONE.
- **DONE** (one cycle):
  - Capture ram_rdata into the owner's rdata. Writes also capture ram_rdata; the value is don't-care.
  - Pulse the owner's ack. Return to IDLE.
  - A grant in IDLE is only possible in the cycle after DONE.
- **Latency:** req sampled in cycle n; ack in cycle n + RAM_LAT + 1. Peak throughput is one access per RAM_LAT + 2 cycles.
- **Request protocol:**
  - Requesters hold req, addr, we and wdata stable until ack.
  - req still high in the cycle after ack means a new access.
  - Dropping req before ack is illegal; the access still completes and the ack is still pulsed.
- **cpu_nwait** = NOT(cpu_req AND NOT cpu_ack), combinational. It reads 1 when cpu_req = 0.
- **wait_cnt** (4-bit, saturating at 15):
  - Increments each cycle cpu_req = 1 and the CPU is not owner.
  - Clears on a CPU grant or when cpu_req = 0.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Losers keep waiting; there is no queueing beyond their held req.
- **Loader starvation** is permitted by design; the loader runs only when video and CPU are idle.
- **Address width:** pass-through, no wrap logic; ADDR_W bits are forwarded unchanged.

Decomposition:
- Shared package zx_mem_pkg:
  - state enum (IDLE, ACCESS, DONE);
  - owner enum (OWN_VID, OWN_CPU, OWN_LDR);
  - constant DATA_W = 8.
- One natural sub-module, zx_prio_pick: combinational priority/starvation selector taking the three reqs, the ack-mask and wait_cnt, returning a one-hot grant.
- Everything else stays in the top FSM.

Test Plan:
- **CPU read:** reset, then cpu_req = 1, addr 0x0A123, RAM holds 0x5C, RAM_LAT = 1 → ram_addr = 0x0A123 one cycle later; cpu_ack at cycle 2 with cpu_rdata = 0x5C; cpu_nwait low for cycles 0–1, high at the ack cycle.
- **CPU write:** cpu_we = 1, addr 0x14000, wdata 0xA5 → ram_we high exactly one cycle with ram_wdata = 0xA5; cpu_ack at cycle 2; a subsequent video read of 0x14000 returns 0xA5.
- **Three-way contention:** vid, cpu and ldr asserted together → acks in order vid, cpu, ldr at cycles 2, 5, 8; no overlapping ram_we.
- **Starvation guard:** vid_req held high continuously, cpu_req asserted → the CPU is granted once wait_cnt reaches 6; wait_cnt then returns to 0 and video resumes.
- **Reset mid-access:** RESET_N = 0 during ACCESS of a CPU write → no cpu_ack, ram_we = 0, state IDLE, all outputs at reset values the next cycle.
- **RAM_LAT = 3:** a CPU read acks at cycle 4; a back-to-back held cpu_req yields acks every 5 cycles.
